// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-word bit positions, access sizes,
// exception-word bit positions and the MEM-stage FSM state type.
package mips_pkg;

  localparam int CW_MEMRD   = 8;
  localparam int CW_MEMWR   = 9;
  localparam int CW_SIZE_LO = 10;
  localparam int CW_SIZE_HI = 11;
  localparam int CW_SEXT    = 12;

  localparam int IC_OV   = 2;
  localparam int IC_ADEL = 3;
  localparam int IC_ADES = 4;
  localparam int IC_DBE  = 5;

  typedef enum logic [1:0] {
    SZ_B  = 2'b00,
    SZ_H  = 2'b01,
    SZ_W  = 2'b10,
    SZ_W2 = 2'b11
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Size 11 is an alias of word, so anything that is not B or H needs a[1:0]==0.
  function automatic logic misaligned(input size_e sz, input logic [1:0] a);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = a[0];
      default: misaligned = |a;
    endcase
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data-memory port: store byte enables and lane
// replication, load lane extraction with sign/zero extension.
module mem_align
  import mips_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      SZ_H: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = rdata_i[7:0];
    case (addr_lo_i)
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      2'd3:    byte_sel = rdata_i[31:24];
      default: byte_sel = rdata_i[7:0];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_B:    rdata_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
      SZ_H:    rdata_o = {{16{sext_i & half_sel[15]}}, half_sel};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: req/ack data-memory access with timeout, alignment
// faults, upstream stall and the falling-edge MEM->WB register.
module mem_stage
  import mips_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALURES,
  input  logic [31:0] MEMDATA,
  input  logic [31:0] CONTROLW_EXE,
  input  logic [7:0]  INTCONTROLW_EXE,
  input  logic [31:0] MEMPC,
  input  logic [31:0] MEMHILO,
  input  logic [6:0]  EXEDES,
  input  logic [1:0]  EXEWRITEHILO,
  output logic        DM_REQ,
  output logic        DM_WE,
  output logic [3:0]  DM_BE,
  output logic [31:0] DM_ADDR,
  output logic [31:0] DM_WDATA,
  input  logic [31:0] DM_RDATA,
  input  logic        DM_ACK,
  output logic        MEM_STALL,
  output logic [6:0]  MEMDES,
  output logic [31:0] MEMRESULT,
  output logic [6:0]  WBDES,
  output logic [1:0]  WBWRITEHILO,
  output logic [31:0] WBDATA,
  output logic [31:0] WBHILO,
  output logic [31:0] WBPC,
  output logic [31:0] CONTROLW_MEM,
  output logic [7:0]  INTCONTROLW_MEM,
  output logic [31:0] BADVADDR
);

  mem_state_e       state_q, state_d;
  logic [TMO_W-1:0] cnt_q, cnt_d;

  logic [6:0]  wb_des_q;
  logic [1:0]  wb_whilo_q;
  logic [31:0] wb_data_q, wb_hilo_q, wb_pc_q, cw_mem_q, badvaddr_q;
  logic [7:0]  int_mem_q;

  logic        mem_rd, mem_wr, memop, sext, mis;
  logic        adel, ades, dbe, fault, timeout, req, stall;
  size_e       sz;
  logic [3:0]  be;
  logic [31:0] st_data, ld_data;
  logic [7:0]  int_word;
  logic        unused_int_bits;

  assign mem_rd  = CONTROLW_EXE[CW_MEMRD];
  assign mem_wr  = CONTROLW_EXE[CW_MEMWR];
  assign sext    = CONTROLW_EXE[CW_SEXT];
  assign sz      = size_e'(CONTROLW_EXE[CW_SIZE_HI:CW_SIZE_LO]);
  assign memop   = mem_rd | mem_wr;
  assign mis     = memop & misaligned(sz, ALURES[1:0]);
  assign adel    = mem_rd & mis;
  assign ades    = mem_wr & mis;
  assign timeout = (state_q == ST_WAIT) && (cnt_q == TMO_W'(ACK_TIMEOUT));
  // An ACK landing on the timeout cycle still completes the access normally.
  assign dbe     = timeout & ~DM_ACK;
  assign fault   = adel | ades | dbe;

  assign req   = ~reset & (((state_q == ST_IDLE) & memop & ~mis) | (state_q == ST_WAIT));
  assign stall = req & ~DM_ACK & ~timeout;

  mem_align u_align (
    .size_i    (sz),
    .addr_lo_i (ALURES[1:0]),
    .sext_i    (sext),
    .wdata_i   (MEMDATA),
    .rdata_i   (DM_RDATA),
    .be_o      (be),
    .wdata_o   (st_data),
    .rdata_o   (ld_data)
  );

  assign DM_REQ    = req;
  assign DM_WE     = req & mem_wr;
  assign DM_BE     = req ? be : 4'b0000;
  assign DM_ADDR   = {ALURES[31:2], 2'b00};
  assign DM_WDATA  = st_data;
  assign MEM_STALL = stall;
  assign MEMDES    = EXEDES;
  assign MEMRESULT = mem_rd ? ld_data : ALURES;

  assign int_word        = {INTCONTROLW_EXE[7:6], dbe, ades, adel, INTCONTROLW_EXE[2:0]};
  assign unused_int_bits = ^INTCONTROLW_EXE[5:3];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req && !DM_ACK) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (DM_ACK || timeout) state_d = ST_IDLE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // MEM -> WB register boundary
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wb_des_q   <= '0;
      wb_whilo_q <= '0;
      wb_data_q  <= '0;
      wb_hilo_q  <= '0;
      wb_pc_q    <= '0;
      cw_mem_q   <= '0;
      int_mem_q  <= '0;
      badvaddr_q <= '0;
    end else if (stall) begin
      wb_des_q   <= '0;
      wb_whilo_q <= '0;
      cw_mem_q   <= '0;
      int_mem_q  <= '0;
    end else begin
      wb_des_q   <= fault ? 7'd0 : EXEDES;
      wb_whilo_q <= fault ? 2'd0 : EXEWRITEHILO;
      wb_data_q  <= MEMRESULT;
      wb_hilo_q  <= MEMHILO;
      wb_pc_q    <= MEMPC;
      cw_mem_q   <= CONTROLW_EXE;
      int_mem_q  <= int_word;
      if (fault) badvaddr_q <= ALURES;
    end
  end

  assign WBDES           = wb_des_q;
  assign WBWRITEHILO     = wb_whilo_q;
  assign WBDATA          = wb_data_q;
  assign WBHILO          = wb_hilo_q;
  assign WBPC            = wb_pc_q;
  assign CONTROLW_MEM    = cw_mem_q;
  assign INTCONTROLW_MEM = int_mem_q;
  assign BADVADDR        = badvaddr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM->WB contents are queued as each
// instruction is driven and compared when the WB register presents them.
module tb_mem_stage;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALURES, MEMDATA, CONTROLW_EXE, MEMPC, MEMHILO, DM_RDATA;
  logic [7:0]  INTCONTROLW_EXE;
  logic [6:0]  EXEDES;
  logic [1:0]  EXEWRITEHILO;
  logic        DM_ACK;
  logic        DM_REQ, DM_WE, MEM_STALL;
  logic [3:0]  DM_BE;
  logic [31:0] DM_ADDR, DM_WDATA, MEMRESULT, WBDATA, WBHILO, WBPC, CONTROLW_MEM, BADVADDR;
  logic [6:0]  MEMDES, WBDES;
  logic [1:0]  WBWRITEHILO;
  logic [7:0]  INTCONTROLW_MEM;

  mem_stage #(.ACK_TIMEOUT(TMO), .TMO_W(8)) dut (
    .clk(clk), .reset(reset), .ALURES(ALURES), .MEMDATA(MEMDATA),
    .CONTROLW_EXE(CONTROLW_EXE), .INTCONTROLW_EXE(INTCONTROLW_EXE), .MEMPC(MEMPC),
    .MEMHILO(MEMHILO), .EXEDES(EXEDES), .EXEWRITEHILO(EXEWRITEHILO),
    .DM_REQ(DM_REQ), .DM_WE(DM_WE), .DM_BE(DM_BE), .DM_ADDR(DM_ADDR),
    .DM_WDATA(DM_WDATA), .DM_RDATA(DM_RDATA), .DM_ACK(DM_ACK), .MEM_STALL(MEM_STALL),
    .MEMDES(MEMDES), .MEMRESULT(MEMRESULT), .WBDES(WBDES), .WBWRITEHILO(WBWRITEHILO),
    .WBDATA(WBDATA), .WBHILO(WBHILO), .WBPC(WBPC), .CONTROLW_MEM(CONTROLW_MEM),
    .INTCONTROLW_MEM(INTCONTROLW_MEM), .BADVADDR(BADVADDR)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  des;
    logic [1:0]  whilo;
    logic [31:0] data;
    logic [31:0] hilo;
    logic [31:0] pc;
    logic [31:0] cw;
    logic [7:0]  intw;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_stall, n_req, n_bub;
  logic [3:0]  s_be;
  logic [31:0] s_wdata, s_addr;
  logic        s_we;
  logic [31:0] pc_ctr = 32'h0040_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_cw(input logic r, input logic w,
                                        input logic [1:0] sz, input logic sx);
    return {19'b0, sx, sz, w, r, 7'b0, 1'b1};
  endfunction

  // Independent load model: shift the addressed lane down, then mask/extend.
  function automatic logic [31:0] ld_model(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a);
    if (sz == 2'b00) return sx ? {{24{s[7]}}, s[7:0]}  : {24'b0, s[7:0]};
    if (sz == 2'b01) return sx ? {{16{s[15]}}, s[15:0]} : {16'b0, s[15:0]};
    return rd;
  endfunction

  task automatic set_nop();
    ALURES = '0; MEMDATA = '0; CONTROLW_EXE = '0; INTCONTROLW_EXE = '0;
    MEMPC = '0; MEMHILO = '0; EXEDES = '0; EXEWRITEHILO = '0;
    DM_RDATA = '0; DM_ACK = 1'b0;
  endtask

  // Entered and left just after a falling edge. delay = cycles without ACK (-1 = never).
  task automatic run_op(input logic [31:0] cw, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input logic [6:0] des, input logic [1:0] wh,
                        input logic [7:0] iw, input int delay,
                        input logic [31:0] xdata, input logic [2:0] xflags);
    wb_t e;
    logic done;
    pc_ctr += 4;
    ALURES = a; MEMDATA = d; CONTROLW_EXE = cw; INTCONTROLW_EXE = iw;
    MEMPC = pc_ctr; MEMHILO = ~pc_ctr; EXEDES = des; EXEWRITEHILO = wh; DM_RDATA = rd;
    e.des   = (xflags != 3'b000) ? 7'd0 : des;
    e.whilo = (xflags != 3'b000) ? 2'd0 : wh;
    e.data  = xdata;
    e.hilo  = ~pc_ctr;
    e.pc    = pc_ctr;
    e.cw    = cw;
    e.intw  = {iw[7:6], xflags, iw[2:0]};
    sb.push_back(e);
    n_stall = 0; n_req = 0; n_bub = 0; done = 1'b0;
    s_be = '0; s_wdata = '0; s_addr = '0; s_we = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      DM_ACK = (delay >= 0) && (c == delay);
      @(posedge clk);
      if (DM_REQ) begin
        if (n_req == 0) begin s_be = DM_BE; s_wdata = DM_WDATA; s_addr = DM_ADDR; s_we = DM_WE; end
        n_req++;
      end
      if (MEM_STALL) n_stall++;
      if (c >= 1 && CONTROLW_MEM == 32'h0 && WBDES == 7'd0) n_bub++;
      done = !MEM_STALL;
      @(negedge clk); #1;
      if (done) break;
    end
    if (!done) chk("op_complete", 32'd0, 32'd1);
    set_nop();
  endtask

  always @(posedge clk) begin
    if (!reset && CONTROLW_MEM != 32'h0) begin
      if (sb.size() == 0) chk("sb_unexpected", CONTROLW_MEM, 32'h0);
      else begin
        mon_e = sb.pop_front();
        chk("wb_des",   WBDES,           mon_e.des);
        chk("wb_whilo", WBWRITEHILO,     mon_e.whilo);
        chk("wb_data",  WBDATA,          mon_e.data);
        chk("wb_hilo",  WBHILO,          mon_e.hilo);
        chk("wb_pc",    WBPC,            mon_e.pc);
        chk("wb_cw",    CONTROLW_MEM,    mon_e.cw);
        chk("wb_int",   INTCONTROLW_MEM, mon_e.intw);
      end
    end
  end

  initial begin
    logic [1:0]  rsz, rlo;
    logic        rsx;
    logic [31:0] rrd, ra;
    int          rdl;
    set_nop();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    chk("rst_req", DM_REQ, 0);       chk("rst_stall", MEM_STALL, 0);
    chk("rst_wbdes", WBDES, 0);      chk("rst_wbdata", WBDATA, 0);
    chk("rst_cw", CONTROLW_MEM, 0);  chk("rst_int", INTCONTROLW_MEM, 0);
    chk("rst_badv", BADVADDR, 0);
    @(negedge clk); #1 reset = 1'b0;

    // SW zero-wait
    run_op(mk_cw(0, 1, 2'b10, 0), 32'h100, 32'hDEADBEEF, 0, 7'd0, 2'b00, 8'h00, 0, 32'h100, 3'b000);
    chk("sw_be", s_be, 4'hF);  chk("sw_wdata", s_wdata, 32'hDEADBEEF);
    chk("sw_we", s_we, 1);     chk("sw_stall", n_stall, 0); chk("sw_req", n_req, 1);
    chk("sw_addr", s_addr, 32'h100);

    // LB sign-extended, ACK after 3 cycles
    run_op(mk_cw(1, 0, 2'b00, 1), 32'h103, 0, 32'h80FF_0000, 7'd5, 2'b00, 8'h00, 3, 32'hFFFFFF80, 3'b000);
    chk("lb_stall", n_stall, 3); chk("lb_bubbles", n_bub, 3); chk("lb_we", s_we, 0);

    // LHU upper half
    run_op(mk_cw(1, 0, 2'b01, 0), 32'h102, 0, 32'hBEEF1234, 7'd6, 2'b00, 8'h00, 1, 32'h0000BEEF, 3'b000);
    chk("lhu_stall", n_stall, 1);

    // SH upper half, SB byte 1
    run_op(mk_cw(0, 1, 2'b01, 0), 32'h102, 32'h0000_5678, 0, 7'd0, 2'b00, 8'h00, 0, 32'h102, 3'b000);
    chk("sh_be", s_be, 4'b1100); chk("sh_wdata", s_wdata, 32'h56785678);
    run_op(mk_cw(0, 1, 2'b00, 0), 32'h101, 32'h1234_56AB, 0, 7'd0, 2'b00, 8'h00, 0, 32'h101, 3'b000);
    chk("sb_be", s_be, 4'b0010); chk("sb_wdata", s_wdata, 32'hABABABAB); chk("sb_addr", s_addr, 32'h100);

    // Misaligned LW -> ADEL, no request
    run_op(mk_cw(1, 0, 2'b10, 0), 32'h101, 0, 0, 7'd7, 2'b11, 8'h00, 0, 32'h0, 3'b001);
    chk("adel_req", n_req, 0); chk("adel_badv", BADVADDR, 32'h101);

    // Misaligned SW -> ADES, store never reaches memory
    run_op(mk_cw(0, 1, 2'b11, 0), 32'h202, 32'h55, 0, 7'd0, 2'b00, 8'h00, 0, 32'h202, 3'b010);
    chk("ades_req", n_req, 0); chk("ades_badv", BADVADDR, 32'h202);

    // Misaligned LH -> ADEL
    run_op(mk_cw(1, 0, 2'b01, 1), 32'h303, 0, 0, 7'd8, 2'b00, 8'h00, 0, 32'h0, 3'b001);
    chk("adel_h_badv", BADVADDR, 32'h303);

    // Non-memory passthrough with a stray ACK; INT bits 5:3 are replaced
    run_op(32'h0000_0001, 32'h0000_1234, 0, 32'hFFFF_FFFF, 7'd9, 2'b10, 8'hFC, 0, 32'h1234, 3'b000);
    chk("alu_req", n_req, 0); chk("alu_stall", n_stall, 0); chk("alu_badv", BADVADDR, 32'h303);
    run_op(mk_cw(1, 0, 2'b10, 0), 32'h400, 0, 32'hCAFEF00D, 7'd10, 2'b00, 8'h00, 2, 32'hCAFEF00D, 3'b000);
    chk("lw_after_ack_stall", n_stall, 2);

    // Random aligned loads against the model
    for (int i = 0; i < 8; i++) begin
      rsz = 2'($urandom_range(0, 3));
      rsx = 1'($urandom_range(0, 1));
      rlo = 2'($urandom_range(0, 3));
      if (rsz == 2'b01) rlo[0] = 1'b0;
      if (rsz[1]) rlo = 2'b00;
      ra  = {$urandom_range(0, 255), 2'b00} | {30'd0, rlo};
      rrd = $urandom;
      rdl = $urandom_range(0, 3);
      run_op(mk_cw(1, 0, rsz, rsx), ra, 0, rrd, 7'(11 + i), 2'b00, 8'h00, rdl,
             ld_model(rsz, rsx, rlo, rrd), 3'b000);
      chk("rnd_stall", n_stall, rdl);
    end

    // ACK never comes: one IDLE request cycle plus WAIT counts 0..TMO
    run_op(mk_cw(1, 0, 2'b10, 0), 32'h500, 0, 0, 7'd20, 2'b01, 8'h00, -1, 32'h0, 3'b100);
    chk("tmo_req", n_req, TMO + 2); chk("tmo_stall", n_stall, TMO + 1);
    chk("tmo_badv", BADVADDR, 32'h500);
    run_op(32'h0000_0001, 32'h0000_0777, 0, 0, 7'd21, 2'b00, 8'h04, 0, 32'h777, 3'b000);
    chk("tmo_idle_req", n_req, 0);

    // Reset asserted in the middle of a WAIT
    pc_ctr += 4;
    ALURES = 32'h600; CONTROLW_EXE = mk_cw(1, 0, 2'b10, 0); EXEDES = 7'd3; MEMPC = pc_ctr; DM_ACK = 1'b0;
    repeat (3) @(posedge clk);
    chk("pre_rst_req", DM_REQ, 1); chk("pre_rst_stall", MEM_STALL, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", DM_REQ, 0);   chk("mid_rst_stall", MEM_STALL, 0);
    chk("mid_rst_data", WBDATA, 0);  chk("mid_rst_pc", WBPC, 0);
    chk("mid_rst_hilo", WBHILO, 0);  chk("mid_rst_badv", BADVADDR, 0);
    chk("mid_rst_int", INTCONTROLW_MEM, 0); chk("mid_rst_des", WBDES, 0);
    @(negedge clk); #1 set_nop();
    @(negedge clk); #1 reset = 1'b0;

    run_op(mk_cw(1, 0, 2'b10, 0), 32'h200, 0, 32'h11223344, 7'd4, 2'b00, 8'h00, 1, 32'h11223344, 3'b000);
    chk("post_rst_req", n_req, 2); chk("post_rst_stall", n_stall, 1);

    repeat (3) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
